// File: rtl/mem_req_port.sv
// Core-side requester for the shared-RAM arbiter: latches a read/write strobe, holds the request until granted, returns data with a done pulse.
// Optional grant-wait timeout enabled by defining MEMREQ_TIMEOUT_EN.
module mem_req_port #(
  parameter int         AW      = 8,
  parameter int         DW      = 8,
  parameter logic [7:0] TIMEOUT = 8'd32
) (
  input  logic          CLK,
  input  logic          rst,
  input  logic          cmd_rd,
  input  logic          cmd_wr,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] rdata,
  output logic          err,
  output logic          rden,
  output logic          wren,
  output logic [AW-1:0] Address,
  output logic [DW-1:0] Din,
  input  logic          acq,
  input  logic [DW-1:0] RAMq
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    RDWAIT = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t state;
  logic   req_wr;

`ifdef MEMREQ_TIMEOUT_EN
  logic [7:0] wait_cnt;
`endif

  // A strobe landing in the done cycle must be ignored, so done gates acceptance.
  logic strobe;
  assign strobe = (cmd_rd | cmd_wr) & ~done;

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      req_wr  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rdata   <= '0;
      rden    <= 1'b0;
      wren    <= 1'b0;
      Address <= '0;
      Din     <= '0;
`ifdef MEMREQ_TIMEOUT_EN
      wait_cnt <= 8'd0;
      err      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef MEMREQ_TIMEOUT_EN
      err  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (strobe) begin
            req_wr  <= cmd_wr;
            Address <= cmd_addr;
            Din     <= cmd_wr ? cmd_wdata : '0;
            wren    <= cmd_wr;
            rden    <= ~cmd_wr;
            busy    <= 1'b1;
            state   <= REQ;
`ifdef MEMREQ_TIMEOUT_EN
            wait_cnt <= 8'd0;
`endif
          end
        end
        REQ: begin
          // Grant beats the timeout when both land on the same edge.
          if (acq) begin
            rden    <= 1'b0;
            wren    <= 1'b0;
            Address <= '0;
            Din     <= '0;
            state   <= req_wr ? DONE : RDWAIT;
          end
`ifdef MEMREQ_TIMEOUT_EN
          else if (wait_cnt == TIMEOUT - 8'd1) begin
            rden    <= 1'b0;
            wren    <= 1'b0;
            Address <= '0;
            Din     <= '0;
            busy    <= 1'b0;
            err     <= 1'b1;
            state   <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
`endif
        end
        RDWAIT: begin
          // The RAM already registered the address, so a dropped grant cannot abort this.
          rdata <= RAMq;
          state <= DONE;
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifndef MEMREQ_TIMEOUT_EN
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_req_port.sv
// Self-checking bench for mem_req_port: behavioural arbiter/RAM, scoreboard of expected completions.
// Timeout scenarios run only when MEMREQ_TIMEOUT_EN is defined.
module tb_mem_req_port;

  logic       CLK = 1'b0;
  logic       rst;
  logic       cmd_rd, cmd_wr;
  logic [7:0] cmd_addr, cmd_wdata;
  logic       busy, done, err, rden, wren, acq;
  logic [7:0] rdata, Address, Din, RAMq;

  typedef struct {
    bit       is_rd;
    bit [7:0] addr;
    bit [7:0] data;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  logic [7:0] mem [256];
  logic [7:0] ram_q = 8'h00;
  int done_cnt = 0, err_cnt = 0, xfer_cnt = 0, overlap_cnt = 0, instab_cnt = 0;
  logic       prev_req = 1'b0;
  logic [7:0] prev_addr = 8'h00, prev_din = 8'h00;

  mem_req_port dut (
    .CLK(CLK), .rst(rst), .cmd_rd(cmd_rd), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .busy(busy), .done(done),
    .rdata(rdata), .err(err), .rden(rden), .wren(wren), .Address(Address),
    .Din(Din), .acq(acq), .RAMq(RAMq)
  );

  always #5 CLK = ~CLK;

  assign RAMq = ram_q;

  // Single-port synchronous RAM behind the arbiter.
  always @(posedge CLK) begin
    if (acq && wren) mem[Address] <= Din;
    if (acq && rden) ram_q <= mem[Address];
  end

  // Protocol monitor: event counts and request stability.
  always @(posedge CLK) begin
    if (done) done_cnt <= done_cnt + 1;
    if (err) err_cnt <= err_cnt + 1;
    if ((rden || wren) && acq) xfer_cnt <= xfer_cnt + 1;
    if (rden && wren) overlap_cnt <= overlap_cnt + 1;
    if ((rden || wren) && prev_req && (Address !== prev_addr || Din !== prev_din))
      instab_cnt <= instab_cnt + 1;
    prev_req  <= rden | wren;
    prev_addr <= Address;
    prev_din  <= Din;
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic issue(input bit rd, input bit wr, input bit [7:0] a, input bit [7:0] d, input bit push);
    exp_t e;
    cmd_rd = rd; cmd_wr = wr; cmd_addr = a; cmd_wdata = d;
    if (push) begin
      e.is_rd = rd && !wr; e.addr = a; e.data = d;
      sb.push_back(e);
    end
    tick;
    cmd_rd = 1'b0; cmd_wr = 1'b0; cmd_addr = 8'h00; cmd_wdata = 8'h00;
  endtask

  task automatic wait_evt(input int start, output int n);
    n = start;
    while (!done && !err && n < start + 200) begin
      tick;
      n++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; acq = 1'b0;
    cmd_rd = 1'b0; cmd_wr = 1'b0; cmd_addr = 8'h00; cmd_wdata = 8'h00;
    #1;
    checks++;
    if ({busy, done, err, rden, wren, rdata, Address, Din} !== 29'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0", {busy, done, err, rden, wren, rdata, Address, Din});
    end
    tick; tick;
    rst = 1'b0;
    tick;
  endtask

  task automatic test_write_immediate;
    int n; exp_t e;
    acq = 1'b1;
    issue(1'b0, 1'b1, 8'h10, 8'hA5, 1'b1);
    checks++;
    if ({wren, rden, busy, Address, Din} !== {3'b101, 8'h10, 8'hA5}) begin
      errors++;
      $display("FAIL wr_req: got wren=%b rden=%b busy=%b addr=%h din=%h want 1 0 1 10 a5", wren, rden, busy, Address, Din);
    end
    tick;
    checks++;
    if (wren !== 1'b0 || Din !== 8'h00) begin
      errors++;
      $display("FAIL wr_req_one_cycle: got wren=%b din=%h want 0 00", wren, Din);
    end
    wait_evt(2, n);
    checks++;
    if (n !== 3 || done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL wr_latency: got cycle=%0d done=%b busy=%b want 3 1 0", n, done, busy);
    end
    e = sb.pop_front();
    checks++;
    if (mem[e.addr] !== e.data) begin
      errors++;
      $display("FAIL wr_data: got mem[%h]=%h want %h", e.addr, mem[e.addr], e.data);
    end
    tick;
  endtask

  task automatic test_read_delayed;
    int n; int hi; exp_t e;
    issue(1'b0, 1'b1, 8'h22, 8'h3C, 1'b1);
    wait_evt(1, n);
    e = sb.pop_front();
    checks++;
    if (mem[e.addr] !== e.data) begin
      errors++;
      $display("FAIL preload_22: got %h want %h", mem[e.addr], e.data);
    end
    tick;
    acq = 1'b0;
    issue(1'b1, 1'b0, 8'h22, 8'h00, 1'b1);
    hi = 0;
    for (int c = 1; c <= 7; c++) begin
      if (rden === 1'b1 && Address === 8'h22) hi++;
      if (c == 6) acq = 1'b1;
      if (c < 7) tick;
    end
    checks++;
    if (hi !== 6 || rden !== 1'b0) begin
      errors++;
      $display("FAIL rd_hold: got %0d cycles rden_after=%b want 6 0", hi, rden);
    end
    wait_evt(7, n);
    checks++;
    if (n !== 9 || done !== 1'b1) begin
      errors++;
      $display("FAIL rd_latency: got cycle=%0d done=%b want 9 1", n, done);
    end
    e = sb.pop_front();
    checks++;
    if (rdata !== 8'h3C || !e.is_rd) begin
      errors++;
      $display("FAIL rd_data: got %h want 3c", rdata);
    end
    tick;
  endtask

  task automatic test_busy_ignore;
    int n; int d0; int x0; exp_t e;
    d0 = done_cnt; x0 = xfer_cnt;
    acq = 1'b1;
    issue(1'b1, 1'b0, 8'h22, 8'h00, 1'b1);
    cmd_rd = 1'b1; cmd_addr = 8'h10;
    tick;
    cmd_rd = 1'b0; cmd_addr = 8'h00;
    wait_evt(2, n);
    e = sb.pop_front();
    checks++;
    if (n !== 4 || rdata !== mem[e.addr]) begin
      errors++;
      $display("FAIL busy_rd: got cycle=%0d rdata=%h want 4 %h", n, rdata, mem[e.addr]);
    end
    repeat (4) tick;
    checks++;
    if (done_cnt - d0 !== 1 || xfer_cnt - x0 !== 1) begin
      errors++;
      $display("FAIL busy_ignore: got dones=%0d xfers=%0d want 1 1", done_cnt - d0, xfer_cnt - x0);
    end
  endtask

  task automatic test_simultaneous;
    int n; int x0; exp_t e;
    x0 = xfer_cnt;
    acq = 1'b1;
    issue(1'b1, 1'b1, 8'h05, 8'h77, 1'b1);
    checks++;
    if (wren !== 1'b1 || rden !== 1'b0) begin
      errors++;
      $display("FAIL both_type: got wren=%b rden=%b want 1 0", wren, rden);
    end
    wait_evt(1, n);
    e = sb.pop_front();
    tick;
    checks++;
    if (mem[8'h05] !== 8'h77 || e.is_rd || xfer_cnt - x0 !== 1) begin
      errors++;
      $display("FAIL both_write: got mem5=%h xfers=%0d want 77 1", mem[8'h05], xfer_cnt - x0);
    end
  endtask

  task automatic test_reset_mid;
    int n; int d0; exp_t e;
    acq = 1'b0;
    issue(1'b1, 1'b0, 8'h10, 8'h00, 1'b0);
    tick;
    rst = 1'b1;
    #1;
    checks++;
    if (rden !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: got rden=%b busy=%b want 0 0", rden, busy);
    end
    d0 = done_cnt;
    tick;
    rst = 1'b0;
    acq = 1'b1;
    repeat (6) tick;
    checks++;
    if (done_cnt - d0 !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_no_done: got dones=%0d busy=%b want 0 0", done_cnt - d0, busy);
    end
    issue(1'b1, 1'b0, 8'h10, 8'h00, 1'b1);
    wait_evt(1, n);
    e = sb.pop_front();
    checks++;
    if (n !== 4 || rdata !== 8'hA5 || !e.is_rd) begin
      errors++;
      $display("FAIL rst_then_rd: got cycle=%0d rdata=%h want 4 a5", n, rdata);
    end
    tick;
  endtask

  task automatic test_back_to_back;
    int n; exp_t e;
    acq = 1'b1;
    issue(1'b0, 1'b1, 8'h30, 8'h5A, 1'b1);
    wait_evt(1, n);
    e = sb.pop_front();
    cmd_rd = 1'b1; cmd_addr = 8'h30;
    tick;
    checks++;
    if (busy !== 1'b0 || rden !== 1'b0) begin
      errors++;
      $display("FAIL done_cycle_strobe: got busy=%b rden=%b want 0 0", busy, rden);
    end
    issue(1'b1, 1'b0, 8'h30, 8'h00, 1'b1);
    checks++;
    if (rden !== 1'b1 || Address !== 8'h30) begin
      errors++;
      $display("FAIL b2b_accept: got rden=%b addr=%h want 1 30", rden, Address);
    end
    wait_evt(1, n);
    e = sb.pop_front();
    checks++;
    if (n !== 4 || rdata !== 8'h5A || !e.is_rd) begin
      errors++;
      $display("FAIL b2b_rd: got cycle=%0d rdata=%h want 4 5a", n, rdata);
    end
    tick;
  endtask

`ifdef MEMREQ_TIMEOUT_EN
  task automatic test_timeout;
    int n; int d0; int e0; exp_t e;
    d0 = done_cnt;
    acq = 1'b0;
    issue(1'b1, 1'b0, 8'h22, 8'h00, 1'b0);
    wait_evt(1, n);
    checks++;
    if (n !== 33 || err !== 1'b1 || done !== 1'b0 || busy !== 1'b0 || rdata !== 8'h5A) begin
      errors++;
      $display("FAIL timeout: got cycle=%0d err=%b done=%b busy=%b rdata=%h want 33 1 0 0 5a", n, err, done, busy, rdata);
    end
    tick; tick;
    checks++;
    if (done_cnt - d0 !== 0) begin
      errors++;
      $display("FAIL timeout_no_done: got dones=%0d want 0", done_cnt - d0);
    end
    e0 = err_cnt;
    issue(1'b1, 1'b0, 8'h22, 8'h00, 1'b1);
    n = 1;
    while (n < 32) begin
      tick;
      n++;
    end
    acq = 1'b1;
    wait_evt(32, n);
    e = sb.pop_front();
    tick;
    checks++;
    if (n !== 35 || err_cnt - e0 !== 0 || rdata !== 8'h3C) begin
      errors++;
      $display("FAIL timeout_grant_wins: got cycle=%0d errs=%0d rdata=%h want 35 0 3c", n, err_cnt - e0, rdata);
    end
  endtask
`endif

  task automatic test_invariants;
    checks++;
    if (overlap_cnt !== 0 || instab_cnt !== 0) begin
      errors++;
      $display("FAIL invariants: got overlap=%0d unstable=%0d want 0 0", overlap_cnt, instab_cnt);
    end
`ifndef MEMREQ_TIMEOUT_EN
    checks++;
    if (err_cnt !== 0) begin
      errors++;
      $display("FAIL err_tied: got %0d err pulses want 0", err_cnt);
    end
`endif
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
    end
  endtask

  initial begin
    test_reset;
    test_write_immediate;
    test_read_delayed;
    test_busy_ignore;
    test_simultaneous;
    test_reset_mid;
    test_back_to_back;
`ifdef MEMREQ_TIMEOUT_EN
    test_timeout;
`endif
    test_invariants;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
